// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
//   Shared types and constants for the LED pattern controller.
//   - state_t    : controller FSM states (IDLE / RUN / PAUSE)
//   - MODE_*     : encoding of the 2-bit mode input
//   - led_seed() : start pattern for an LED bank of a given width (bit 0 lit)
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROTATE_L = 2'd0;
    localparam logic [1:0] MODE_ROTATE_R = 2'd1;
    localparam logic [1:0] MODE_BOUNCE   = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    localparam int unsigned NLED_MAX = 16;

    // Seed pattern: only the lowest LED of the bank lit.
    function automatic logic [NLED_MAX-1:0] led_seed(input int unsigned nled);
        logic [NLED_MAX-1:0] v;
        v = '0;
        if (nled > 0) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//   Step-interval divider. Counts while run is high and pulses tick for one
//   cycle when the count reaches TICK_DIV-1, wrapping to 0. Holds its count
//   while run is low; clear forces the count back to 0.
// Ports:
//   clk   - clock (posedge)
//   rst_n - asynchronous active-low reset
//   run   - advance the divider this cycle
//   clear - synchronous clear of the divider count (wins over run)
//   tick  - one-cycle step pulse
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign tick = run && (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   LED bank pattern sequencer with start/pause/stop control. One pattern
//   step per TICK_DIV clock cycles while running; mode is sampled on steps.
//   Optional feature macro: LED_BOUNCE_EN (builds BOUNCE mode and the
//   direction register; without it mode 2 behaves as ROTATE_L).
// Ports:
//   clk   - clock (posedge)
//   rst_n - asynchronous active-low reset
//   start - IDLE->RUN or PAUSE->RUN (level)
//   pause - RUN->PAUSE (level)
//   stop  - any state->IDLE (level); priority stop > pause > start
//   mode  - 0 ROTATE_L, 1 ROTATE_R, 2 BOUNCE, 3 BLINK
//   led   - registered LED drive
//   busy  - registered, high when not IDLE
//   tick  - one-cycle pulse on each pattern step
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NLED     = 8,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            pause,
    input  logic            stop,
    input  logic [1:0]      mode,
    output logic [NLED-1:0] led,
    output logic            busy,
    output logic            tick
);

    localparam logic [NLED_MAX-1:0] SEED_FULL = led_seed(NLED);
    localparam logic [NLED-1:0]     SEED      = SEED_FULL[NLED-1:0];

    state_t          r_state, w_next;
    logic [NLED-1:0] r_led, w_step_led;
    logic            r_busy;
    logic            w_run, w_clear, w_tick, w_saturated;
`ifdef LED_BOUNCE_EN
    logic            r_dir_right, w_step_dir_right;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A higher-priority command masks lower ones in every state.
    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (start && !pause) w_next = ST_RUN;
                ST_RUN:   if (pause)           w_next = ST_PAUSE;
                ST_PAUSE: if (start && !pause) w_next = ST_RUN;
                default:                       w_next = ST_IDLE;
            endcase
        end
    end

    // The divider freezes in the cycle a pause/stop is seen, so the held
    // count is the one present when the command arrived.
    assign w_run   = (r_state == ST_RUN) && !pause && !stop;
    assign w_clear = stop || (r_state == ST_IDLE);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_saturated = (r_led == '0) || (r_led == '1);

    always_comb begin
        w_step_led = r_led;
`ifdef LED_BOUNCE_EN
        w_step_dir_right = r_dir_right;
`endif
        if (mode == MODE_BLINK) begin
            w_step_led = (r_led == '1) ? '0 : '1;
        end else if (w_saturated) begin
            w_step_led = SEED;
`ifdef LED_BOUNCE_EN
            w_step_dir_right = 1'b0;
`endif
        end else begin
            case (mode)
                MODE_ROTATE_R: w_step_led = {r_led[0], r_led[NLED-1:1]};
`ifdef LED_BOUNCE_EN
                MODE_BOUNCE: begin
                    // Reverse as the lit bit lands on an end, so it dwells
                    // there for exactly one step.
                    if (r_dir_right) begin
                        w_step_led = {1'b0, r_led[NLED-1:1]};
                        if (r_led[1]) w_step_dir_right = 1'b0;
                    end else begin
                        w_step_led = {r_led[NLED-2:0], 1'b0};
                        if (r_led[NLED-2]) w_step_dir_right = 1'b1;
                    end
                end
`endif
                default: w_step_led = {r_led[NLED-2:0], r_led[NLED-1]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            if (w_next == ST_IDLE) begin
                r_led <= '0;
            end else if (r_state == ST_IDLE) begin
                r_led <= SEED;
            end else if (w_tick) begin
                r_led <= w_step_led;
            end
        end
    end

`ifdef LED_BOUNCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_right <= 1'b0;
        end else if (w_next == ST_IDLE || r_state == ST_IDLE) begin
            r_dir_right <= 1'b0;
        end else if (w_tick) begin
            r_dir_right <= w_step_dir_right;
        end
    end
`endif

    assign led  = r_led;
    assign busy = r_busy;
    assign tick = w_tick;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, stop;
    logic [1:0] mode;
    logic [7:0] led;
    logic       busy, tick;

    led_pattern_ctrl #(
        .NLED     (8),
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pause (pause),
        .stop  (stop),
        .mode  (mode),
        .led   (led),
        .busy  (busy),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: state 0 idle, 1 run, 2 pause; m_phase = cycles
    // accumulated toward the next step; m_dir +1 left, -1 right.
    int         m_st;
    int         m_phase;
    int         m_dir;
    logic [7:0] m_led;

    logic [7:0] s_led;
    logic       s_busy, s_tick;

    typedef struct {
        logic       st, pa, sp;
        logic [1:0] md;
        logic [7:0] led;
        logic       busy, tick;
    } vec_t;
    vec_t tbl[13];

    logic [7:0] exp_b[16];

    task automatic model_reset();
        m_st = 0; m_phase = 0; m_dir = 1; m_led = 8'h00;
    endtask

    task automatic model_pattern(input logic [1:0] m);
        int eff;
        int v;
        eff = int'(m);
`ifndef LED_BOUNCE_EN
        if (eff == 2) eff = 0;
`endif
        v = int'(m_led);
        if (eff == 3) begin
            v = (v == 255) ? 0 : 255;
        end else if (v == 0 || v == 255) begin
            v = 1; m_dir = 1;
        end else if (eff == 0) begin
            v = ((v * 2) + (v / 128)) % 256;
        end else if (eff == 1) begin
            v = (v / 2) + ((v % 2) * 128);
        end else begin
            if (m_dir > 0) begin
                v = (v * 2) % 256;
                if (v >= 128) m_dir = -1;
            end else begin
                v = v / 2;
                if (v % 2 == 1) m_dir = 1;
            end
        end
        m_led = 8'(v);
    endtask

    task automatic model_edge(input logic s, input logic p, input logic k, input logic [1:0] m);
        if (k) begin
            model_reset();
        end else if (m_st == 0) begin
            if (s && !p) begin m_st = 1; m_led = 8'h01; m_phase = 0; m_dir = 1; end
        end else if (m_st == 1) begin
            if (p) m_st = 2;
            else if (m_phase == TD - 1) begin m_phase = 0; model_pattern(m); end
            else m_phase = m_phase + 1;
        end else begin
            if (s && !p) m_st = 1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive (just after posedge), sample at negedge,
    // compare against the model, then advance the model at the edge.
    task automatic cyc(input logic s, input logic p, input logic k, input logic [1:0] m);
        logic e_tick;
        start = s; pause = p; stop = k; mode = m;
        @(negedge clk);
        s_led = led; s_busy = busy; s_tick = tick;
        e_tick = (m_st == 1) && !p && !k && (m_phase == TD - 1);
        n_vec++;
        if (s_led !== m_led || s_busy !== (m_st != 0) || s_tick !== e_tick) begin
            n_err++;
            $display("FAIL model t=%0t: led=%h busy=%b tick=%b, expected led=%h busy=%b tick=%b",
                     $time, s_led, s_busy, s_tick, m_led, (m_st != 0), e_tick);
        end
        model_edge(s, p, k, m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed vector table: one row per cycle from a fresh reset.
        tbl[0]  = '{0,0,0,0, 8'h00,0,0};
        tbl[1]  = '{1,0,0,0, 8'h00,0,0};
        tbl[2]  = '{0,0,0,0, 8'h01,1,0};
        tbl[3]  = '{0,0,0,0, 8'h01,1,0};
        tbl[4]  = '{0,0,0,0, 8'h01,1,0};
        tbl[5]  = '{0,0,0,0, 8'h01,1,1};
        tbl[6]  = '{0,0,0,0, 8'h02,1,0};
        tbl[7]  = '{0,0,0,0, 8'h02,1,0};
        tbl[8]  = '{0,0,0,0, 8'h02,1,0};
        tbl[9]  = '{0,0,0,0, 8'h02,1,1};
        tbl[10] = '{1,1,1,0, 8'h04,1,0};
        tbl[11] = '{0,0,0,0, 8'h00,0,0};
        tbl[12] = '{0,0,0,0, 8'h00,0,0};

`ifdef LED_BOUNCE_EN
        exp_b = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,
                  8'h40,8'h20,8'h10,8'h08,8'h04,8'h02,8'h01,8'h02};
`else
        exp_b = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,
                  8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80};
`endif

        rst_n = 1'b0; start = 0; pause = 0; stop = 0; mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_led", int'(led), 0);
        chk("reset_busy_tick", int'({busy, tick}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].pa, tbl[i].sp, tbl[i].md);
            chk($sformatf("table[%0d]", i), int'({s_led, s_busy, s_tick}),
                int'({tbl[i].led, tbl[i].busy, tbl[i].tick}));
        end

        // Rotate-left full lap with tick cadence.
        cyc(0,0,1,0);
        cyc(1,0,0,0);
        for (int k = 0; k <= 32; k++) begin
            cyc(0,0,0,0);
            if (k == 0)  chk("rotl_entry", int'(s_led), 8'h01);
            if (k == 4)  chk("rotl_+4",    int'(s_led), 8'h02);
            if (k == 28) chk("rotl_+28",   int'(s_led), 8'h80);
            if (k == 32) chk("rotl_+32",   int'(s_led), 8'h01);
            chk($sformatf("rotl_tick_%0d", k), int'(s_tick), (k % 4 == 3) ? 1 : 0);
        end

        // Mode 2 sequence (bounce, or rotate-left when not built).
        cyc(0,0,1,2);
        cyc(1,0,0,2);
        for (int k = 0; k <= 60; k++) begin
            cyc(0,0,0,2);
            if (k % 4 == 0) chk($sformatf("mode2_step%0d", k / 4), int'(s_led), int'(exp_b[k / 4]));
        end

        // Blink for three steps, then rotate-right.
        cyc(0,0,1,3);
        cyc(1,0,0,3);
        for (int k = 0; k <= 20; k++) begin
            cyc(0,0,0, (k < 12) ? 2'd3 : 2'd1);
            if (k == 4)  chk("blink_1", int'(s_led), 8'hFF);
            if (k == 8)  chk("blink_2", int'(s_led), 8'h00);
            if (k == 12) chk("blink_3", int'(s_led), 8'hFF);
            if (k == 16) chk("rotr_seed", int'(s_led), 8'h01);
            if (k == 20) chk("rotr_1", int'(s_led), 8'h80);
        end

        // Pause at count 2 for 10 cycles, then resume.
        cyc(0,0,1,0);
        cyc(1,0,0,0);
        for (int k = 0; k <= 15; k++) begin
            cyc(k == 12, (k >= 2 && k <= 11), 0, 0);
            if (k >= 3 && k <= 12) begin
                chk($sformatf("pause_hold_%0d", k), int'({s_led, s_busy, s_tick}), int'({8'h01, 1'b1, 1'b0}));
            end
            if (k == 13) chk("resume_tick0", int'(s_tick), 0);
            if (k == 14) chk("resume_tick1", int'(s_tick), 1);
            if (k == 15) chk("resume_step", int'(s_led), 8'h02);
        end

        // Asynchronous reset between edges during RUN.
        cyc(0,0,1,0);
        cyc(1,0,0,0);
        repeat (6) cyc(0,0,0,0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", int'({led, busy, tick}), 0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            cyc(0,0,0,0);
            chk($sformatf("post_rst_%0d", k), int'({s_led, s_busy, s_tick}), 0);
        end

        // Randomized commands and mode changes against the model.
        begin
            logic [1:0] rm;
            rm = 2'd0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom % 8 == 0) rm = 2'($urandom_range(0, 3));
                cyc(($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 40) == 0, rm);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
